// File: rtl/lstm_addr_pkg.sv
// ---------------------------------------------------------------------------
// lstm_addr_pkg
// Shared definitions for the LSTM c/h state-memory address generators.
//   state_e        : sequencer states {IDLE, RUN, DONE}
//   *_DEF          : default geometry (12-bit addresses, 16-bit words,
//                    53 cells x 7 timesteps)
//   TOTAL          : beats per sequence for the default geometry
//   cnt_w()        : clog2-based counter width, never narrower than 1 bit
// ---------------------------------------------------------------------------
package lstm_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int NUM_CELLS_DEF  = 53;
  localparam int TIMESTEP_DEF   = 7;
  localparam int TOTAL          = NUM_CELLS_DEF * TIMESTEP_DEF;

  // Width needed to count 0..n-1; a 1-deep counter still gets one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addr_gen_c_wr_if.sv
// ---------------------------------------------------------------------------
// addr_gen_c_wr_if
// Beat channel from the elementwise stage plus the shared c/h state-memory
// write port of addr_gen_c_wr.
//   i_valid / i_ready      : beat handshake (accept when both are high)
//   i_c / i_h              : c_t and h_t for the current cell
//   o_we                   : write enable shared by the c and h memories
//   o_addr_c / o_addr_h    : write addresses (always equal)
//   o_data_c / o_data_h    : write data
// Modports: slave = the address generator, master = upstream stage / memory
// side (used by a testbench or an integration wrapper).
// ---------------------------------------------------------------------------
interface addr_gen_c_wr_if
  import lstm_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                         i_valid;
  logic                         i_ready;
  logic signed [DATA_WIDTH-1:0] i_c;
  logic signed [DATA_WIDTH-1:0] i_h;
  logic                         o_we;
  logic        [ADDR_WIDTH-1:0] o_addr_c;
  logic        [ADDR_WIDTH-1:0] o_addr_h;
  logic signed [DATA_WIDTH-1:0] o_data_c;
  logic signed [DATA_WIDTH-1:0] o_data_h;

  modport slave (
    input  i_valid, i_c, i_h,
    output i_ready, o_we, o_addr_c, o_addr_h, o_data_c, o_data_h
  );

  modport master (
    output i_valid, i_c, i_h,
    input  i_ready, o_we, o_addr_c, o_addr_h, o_data_c, o_data_h
  );

endinterface

// File: rtl/addr_gen_c_wr.sv
// ---------------------------------------------------------------------------
// addr_gen_c_wr
// Write-side address generator for the LSTM cell (c) and hidden (h) state
// memories. Takes one c_t/h_t beat per cell over a valid/ready handshake and
// writes it to address base+cell, walking NUM_CELLS cells for each of
// TIMESTEP timesteps. o_done rises with the final write so the next layer or
// the BPTT pass can start reading.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous, active-high reset
//   en       : global enable; low freezes all state and drops i_ready
//   i_start  : one-cycle pulse starting a sequence at address 0
//   bus      : addr_gen_c_wr_if.slave (beat handshake + memory write port)
//   o_busy   : high exactly while the sequencer is in RUN
//   o_done   : high from the final write until the next accepted i_start
//   o_step   : (STEP_PULSE_EN only) one-cycle pulse with the write of the
//              last cell of each timestep
//
// Configuration macro: STEP_PULSE_EN (adds the o_step port and its logic).
//
// All outputs except i_ready are registered; write latency is one cycle from
// the accepting edge.
// ---------------------------------------------------------------------------
module addr_gen_c_wr
  import lstm_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_CELLS  = NUM_CELLS_DEF,
  parameter int TIMESTEP   = TIMESTEP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            i_start,
  addr_gen_c_wr_if.slave  bus,
  output logic            o_busy,
  output logic            o_done
`ifdef STEP_PULSE_EN
  ,
  output logic            o_step
`endif
);

  localparam int CELL_W = cnt_w(NUM_CELLS);
  localparam int TS_W   = cnt_w(TIMESTEP);

  localparam logic [CELL_W-1:0]     CELL_LAST = CELL_W'(NUM_CELLS - 1);
  localparam logic [TS_W-1:0]       TS_LAST   = TS_W'(TIMESTEP - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_STEP = ADDR_WIDTH'(NUM_CELLS);

  // The whole sequence must fit in the address space.
  generate
    if ((longint'(NUM_CELLS) * longint'(TIMESTEP)) > (longint'(1) << ADDR_WIDTH)) begin : g_width_chk
      $error("addr_gen_c_wr: NUM_CELLS*TIMESTEP exceeds 2**ADDR_WIDTH");
    end
  endgenerate

  state_e                       state_q,    state_d;
  logic        [CELL_W-1:0]     cell_cnt_q, cell_cnt_d;
  logic        [TS_W-1:0]       ts_cnt_q,   ts_cnt_d;
  logic        [ADDR_WIDTH-1:0] base_q,     base_d;

  logic                         we_q,       we_d;
  logic        [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic signed [DATA_WIDTH-1:0] data_c_q,   data_c_d;
  logic signed [DATA_WIDTH-1:0] data_h_q,   data_h_d;
  logic                         busy_q,     busy_d;
  logic                         done_q,     done_d;
`ifdef STEP_PULSE_EN
  logic                         step_q,     step_d;
`endif

  logic ready;
  logic accept;
  logic last_cell;
  logic last_ts;

  // i_ready is the one combinational output: it must follow en in the same
  // cycle so a frozen block never takes a beat.
  assign ready     = en && (state_q == RUN);
  assign accept    = bus.i_valid && ready;
  assign last_cell = (cell_cnt_q == CELL_LAST);
  assign last_ts   = (ts_cnt_q == TS_LAST);

  always_comb begin
    state_d    = state_q;
    cell_cnt_d = cell_cnt_q;
    ts_cnt_d   = ts_cnt_q;
    base_d     = base_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_c_d   = data_c_q;
    data_h_d   = data_h_q;
`ifdef STEP_PULSE_EN
    step_d     = 1'b0;
`endif

    if (en) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (i_start) begin
            state_d    = RUN;
            cell_cnt_d = '0;
            ts_cnt_d   = '0;
            base_d     = '0;
          end
        end
        RUN: begin
          // i_start is deliberately ignored while a sequence is running.
          if (accept) begin
            we_d     = 1'b1;
            addr_d   = base_q + ADDR_WIDTH'(cell_cnt_q);
            data_c_d = bus.i_c;
            data_h_d = bus.i_h;
            if (last_cell) begin
              cell_cnt_d = '0;
              ts_cnt_d   = ts_cnt_q + 1'b1;
              base_d     = base_q + BASE_STEP;
`ifdef STEP_PULSE_EN
              step_d     = 1'b1;
`endif
              if (last_ts) begin
                state_d = DONE;
              end
            end else begin
              cell_cnt_d = cell_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status is derived from the next state so that busy/done switch on the
    // same edge as the final write.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // ---- sequencer: FSM state and counters ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cell_cnt_q <= '0;
      ts_cnt_q   <= '0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      cell_cnt_q <= cell_cnt_d;
      ts_cnt_q   <= ts_cnt_d;
      base_q     <= base_d;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_c_q <= '0;
      data_h_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef STEP_PULSE_EN
      step_q   <= 1'b0;
`endif
    end else begin
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_c_q <= data_c_d;
      data_h_q <= data_h_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef STEP_PULSE_EN
      step_q   <= step_d;
`endif
    end
  end

  assign bus.i_ready  = ready;
  assign bus.o_we     = we_q;
  assign bus.o_addr_c = addr_q;
  assign bus.o_addr_h = addr_q;
  assign bus.o_data_c = data_c_q;
  assign bus.o_data_h = data_h_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
`ifdef STEP_PULSE_EN
  assign o_step       = step_q;
`endif

endmodule

// File: tb/tb_addr_gen_c_wr.sv
// ---------------------------------------------------------------------------
// tb_addr_gen_c_wr
// Scoreboard bench for addr_gen_c_wr: accepted beats push the expected write
// into a queue; an independent monitor pops and compares on every o_we.
// Build with +define+STEP_PULSE_EN to also check o_step.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_addr_gen_c_wr;
  import lstm_addr_pkg::*;

  localparam int NC = NUM_CELLS_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic i_start = 1'b0;
  logic o_busy;
  logic o_done;
`ifdef STEP_PULSE_EN
  logic o_step;
`endif

  addr_gen_c_wr_if #(.ADDR_WIDTH(ADDR_WIDTH_DEF), .DATA_WIDTH(DATA_WIDTH_DEF)) bus ();

  addr_gen_c_wr dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .i_start (i_start),
    .bus     (bus),
    .o_busy  (o_busy),
    .o_done  (o_done)
`ifdef STEP_PULSE_EN
    ,
    .o_step  (o_step)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 addr;
    logic signed [15:0] c;
    logic signed [15:0] h;
    int                 cyc;
    bit                 step;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   exp_addr = 0;
  int   beat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic signed [15:0] dc(input int b);
    return 16'(b * 37 + 5);
  endfunction

  function automatic logic signed [15:0] dh(input int b);
    return 16'hA000 ^ 16'(b);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Accept detector: inputs are stable at negedge, so this is the beat the
  // coming edge will take.
  always @(negedge clk) begin
    if (!rst && bus.i_valid && bus.i_ready) begin
      q.push_back('{exp_addr, bus.i_c, bus.i_h, cyc, ((exp_addr % NC) == NC - 1)});
      exp_addr++;
    end
  end

  // Monitor: compares every write against the scoreboard head.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (bus.o_we) begin
      if (q.size() == 0) begin
        check("spurious_we", {20'd0, bus.o_addr_c}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("we_latency", cyc, e.cyc + 1);
        check("addr_c", {20'd0, bus.o_addr_c}, e.addr);
        check("addr_h", {20'd0, bus.o_addr_h}, e.addr);
        check("data_c", 32'(bus.o_data_c), 32'(e.c));
        check("data_h", 32'(bus.o_data_h), 32'(e.h));
        check("busy_at_write", o_busy, (e.addr == TOTAL - 1) ? 0 : 1);
        check("done_at_write", o_done, (e.addr == TOTAL - 1) ? 1 : 0);
`ifdef STEP_PULSE_EN
        check("step", o_step, e.step);
`endif
      end
    end else begin
      if (q.size() > 0 && q[0].cyc + 1 <= cyc) begin
        e = q.pop_front();
        check("missing_we", 0, e.addr + 1);
      end
`ifdef STEP_PULSE_EN
      if (o_step) check("step_without_we", o_step, 0);
`endif
    end
  end

  // Called at posedge+1.
  task automatic do_start(input bit restart_model);
    i_start = 1'b1;
    en = 1'b1;
    if (restart_model) begin
      exp_addr = 0;
      beat = 0;
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    check("done_after_start", o_done, 0);
  endtask

  // Present beats until beat index reaches target; optional 1/0 valid toggle.
  task automatic drive_until(input int target, input bit toggle);
    int  c = 0;
    int  limit = 2 * (target - beat) + 20;
    bit  ph = 1'b1;
    while (beat < target && c < limit) begin
      bus.i_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      bus.i_c = dc(beat);
      bus.i_h = dh(beat);
      #0;
      if (bus.i_valid && bus.i_ready) beat++;
      @(posedge clk); #1;
      c++;
    end
    bus.i_valid = 1'b0;
    if (beat < target) check("drive_timeout", beat, target);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"},     bus.o_we, 0);
    check({tag, "_addr_c"}, {20'd0, bus.o_addr_c}, 0);
    check({tag, "_addr_h"}, {20'd0, bus.o_addr_h}, 0);
    check({tag, "_data_c"}, 32'(bus.o_data_c), 0);
    check({tag, "_data_h"}, 32'(bus.o_data_h), 0);
    check({tag, "_busy"},   o_busy, 0);
    check({tag, "_done"},   o_done, 0);
    check({tag, "_ready"},  bus.i_ready, 0);
`ifdef STEP_PULSE_EN
    check({tag, "_step"},   o_step, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_valid = 1'b0;
    bus.i_c = '0;
    bus.i_h = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    en = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", bus.i_ready, 0);

    // Full sequence with valid held high
    do_start(1'b1);
    drive_until(TOTAL, 1'b0);
    check("seq1_done", o_done, 1);
    check("seq1_busy", o_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("seq1_done_hold", o_done, 1);
    check("seq1_ready_done", bus.i_ready, 0);
    check("seq1_drained", q.size(), 0);

    // Full sequence with valid toggling every cycle
    do_start(1'b1);
    drive_until(TOTAL, 1'b1);
    @(posedge clk); #1;
    check("seq2_done", o_done, 1);
    check("seq2_drained", q.size(), 0);

    // Enable dropped for 5 cycles at beat 100 while valid stays high
    do_start(1'b1);
    drive_until(100, 1'b0);
    en = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_c = dc(beat);
    bus.i_h = dh(beat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("en0_ready", bus.i_ready, 0);
      check("en0_we", bus.o_we, 0);
      check("en0_busy", o_busy, 1);
    end
    bus.i_valid = 1'b0;
    en = 1'b1;
    drive_until(TOTAL, 1'b0);
    @(posedge clk); #1;
    check("seq3_done", o_done, 1);
    check("seq3_drained", q.size(), 0);

    // Reset mid-sequence at beat 200, then restart
    do_start(1'b1);
    drive_until(200, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("midrst");
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_drained", q.size(), 0);
    do_start(1'b1);
    drive_until(60, 1'b0);
    // Start pulse in RUN: must not restart addressing
    do_start(1'b0);
    drive_until(TOTAL, 1'b1);
    @(posedge clk); #1;
    check("seq4_done", o_done, 1);
    check("seq4_busy", o_busy, 0);

    repeat (3) @(posedge clk);
    #1;
    check("final_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
